// File: rtl/mem_stage_lsu.sv
// Pipeline memory stage with a load/store unit between EX/MEM and MEM/WB.
// Supports sized and signed loads/stores, byte enables, and a req/gnt/rvalid
// bus with variable latency. Misaligned accesses and bus timeouts retire as
// exceptions. mem_busy tells the hazard unit to hold upstream stages.
module mem_stage_lsu #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    hazard_stall,
  input  logic                    hazard_flush,
  input  logic                    EX_MEM_enable_out,
  input  logic [31:0]             EX_MEM_PC,
  input  logic [DATA_WIDTH-1:0]   EX_MEM_ALUResult,
  input  logic [DATA_WIDTH-1:0]   EX_MEM_WriteData,
  input  logic [2:0]              EX_MEM_Funct3,
  input  logic [4:0]              EX_MEM_Rd,
  input  logic                    EX_MEM_MemRead,
  input  logic                    EX_MEM_MemWrite,
  input  logic                    EX_MEM_MemToReg,
  input  logic                    EX_MEM_RegWrite,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [ADDR_WIDTH-1:0]   dmem_addr,
  output logic [DATA_WIDTH-1:0]   dmem_wdata,
  output logic [DATA_WIDTH/8-1:0] dmem_be,
  input  logic                    dmem_gnt,
  input  logic                    dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]   dmem_rdata,
  output logic                    mem_busy,
  output logic [31:0]             MEM_WB_PC,
  output logic [DATA_WIDTH-1:0]   MEM_WB_ReadData,
  output logic [DATA_WIDTH-1:0]   MEM_WB_ALUResult,
  output logic [4:0]              MEM_WB_Rd,
  output logic                    MEM_WB_RegWrite,
  output logic                    MEM_WB_MemToReg,
  output logic                    MEM_WB_enable_out,
  output logic                    MEM_WB_exc,
  output logic [1:0]              MEM_WB_exc_code
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state;
  logic [1:0]            next_state;
  logic [CNT_WIDTH-1:0]  cnt;

  logic [31:0]           cap_pc;
  logic [DATA_WIDTH-1:0] cap_alu;
  logic [4:0]            cap_rd;
  logic                  cap_regwrite;
  logic                  cap_memtoreg;
  logic                  cap_load;
  logic                  cap_unsigned;
  logic [1:0]            cap_size;
  logic [OFFW-1:0]       cap_off;

  logic [1:0]            in_size;
  logic [OFFW-1:0]       in_off;
  logic [OFFW-1:0]       size_mask;
  logic                  in_is_mem;
  logic                  in_misaligned;
  logic                  accept;
  logic                  accept_mem;
  logic [3:0]            in_bytes;
  logic [15:0]           be_wide;
  logic [NB-1:0]         in_be;
  logic [DATA_WIDTH-1:0] in_wdata;

  logic [DATA_WIDTH-1:0] shifted;
  logic [6:0]            ld_bits;
  logic [DATA_WIDTH-1:0] ld_mask;
  logic [DATA_WIDTH-1:0] ld_top;
  logic                  ld_sign;
  logic [DATA_WIDTH-1:0] load_data;

  logic                  timeout_hit;
  logic                  fin_store;
  logic                  fin_load;
  logic                  fin_timeout;

  assign in_size    = EX_MEM_Funct3[1:0];
  assign in_off     = EX_MEM_ALUResult[OFFW-1:0];
  assign in_is_mem  = EX_MEM_MemRead | EX_MEM_MemWrite;
  assign accept     = (state == S_IDLE) && EX_MEM_enable_out && !hazard_stall && !hazard_flush;
  assign accept_mem = accept && in_is_mem && !in_misaligned;
  assign mem_busy   = (state != S_IDLE) || accept_mem;
  assign dmem_req   = (state == S_REQ);
  assign timeout_hit = (cnt >= CNT_LAST);

  // Decode the incoming access: alignment, byte lanes and replicated store data.
  always_comb begin
    size_mask = '0;
    in_wdata  = EX_MEM_WriteData;
    case (in_size)
      2'b00: begin
        size_mask = '0;
        in_wdata  = {NB{EX_MEM_WriteData[7:0]}};
      end
      2'b01: begin
        size_mask = OFFW'(1);
        in_wdata  = {(NB/2){EX_MEM_WriteData[15:0]}};
      end
      2'b10: begin
        size_mask = OFFW'(3);
        in_wdata  = {(NB/4){EX_MEM_WriteData[31:0]}};
      end
      default: begin
        size_mask = OFFW'(7);
        in_wdata  = EX_MEM_WriteData;
      end
    endcase
    in_misaligned = ((in_off & size_mask) != '0) || ((in_size == 2'b11) && (DATA_WIDTH == 32));
    in_bytes      = 4'd1 << in_size;
    be_wide       = ((16'd1 << in_bytes) - 16'd1) << in_off;
    in_be         = be_wide[NB-1:0];
  end

  // Shift the returned word down to the addressed lane, then truncate and extend.
  always_comb begin
    shifted   = dmem_rdata >> {cap_off, 3'b000};
    ld_bits   = 7'd8 << cap_size;
    ld_mask   = ~({DATA_WIDTH{1'b1}} << ld_bits);
    ld_top    = ld_mask ^ (ld_mask >> 1);
    ld_sign   = !cap_unsigned && (|(shifted & ld_top));
    load_data = (shifted & ld_mask) | (ld_sign ? ~ld_mask : '0);
  end

  // Next-state logic; a flush always wins, then completion, then timeout.
  always_comb begin
    next_state  = state;
    fin_store   = 1'b0;
    fin_load    = 1'b0;
    fin_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept_mem) next_state = S_REQ;
      end
      S_REQ: begin
        if (hazard_flush) begin
          next_state = (dmem_gnt && cap_load) ? S_DRAIN : S_IDLE;
        end else if (dmem_gnt) begin
          if (cap_load) begin
            next_state = S_RESP;
          end else begin
            next_state = S_IDLE;
            fin_store  = 1'b1;
          end
        end else if (timeout_hit) begin
          next_state  = S_IDLE;
          fin_timeout = 1'b1;
        end
      end
      S_RESP: begin
        if (hazard_flush) begin
          next_state = dmem_rvalid ? S_IDLE : S_DRAIN;
        end else if (dmem_rvalid) begin
          next_state = S_IDLE;
          fin_load   = 1'b1;
        end else if (timeout_hit) begin
          next_state  = S_IDLE;
          fin_timeout = 1'b1;
        end
      end
      S_DRAIN: begin
        if (dmem_rvalid) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // State, timeout counter and captured operands/bus signals for the access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      cap_pc       <= '0;
      cap_alu      <= '0;
      cap_rd       <= '0;
      cap_regwrite <= 1'b0;
      cap_memtoreg <= 1'b0;
      cap_load     <= 1'b0;
      cap_unsigned <= 1'b0;
      cap_size     <= '0;
      cap_off      <= '0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= '0;
    end else begin
      state <= next_state;
      if (accept_mem) begin
        cnt          <= '0;
        cap_pc       <= EX_MEM_PC;
        cap_alu      <= EX_MEM_ALUResult;
        cap_rd       <= EX_MEM_Rd;
        cap_regwrite <= EX_MEM_RegWrite;
        cap_memtoreg <= EX_MEM_MemToReg;
        cap_load     <= EX_MEM_MemRead;
        cap_unsigned <= EX_MEM_Funct3[2];
        cap_size     <= in_size;
        cap_off      <= in_off;
        dmem_we      <= EX_MEM_MemWrite && !EX_MEM_MemRead;
        dmem_addr    <= {EX_MEM_ALUResult[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
        dmem_wdata   <= in_wdata;
        dmem_be      <= in_be;
      end else if ((state == S_REQ) || (state == S_RESP)) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

  // MEM/WB register: one-cycle retire pulse, payload held between retires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      MEM_WB_PC         <= '0;
      MEM_WB_ReadData   <= '0;
      MEM_WB_ALUResult  <= '0;
      MEM_WB_Rd         <= '0;
      MEM_WB_RegWrite   <= 1'b0;
      MEM_WB_MemToReg   <= 1'b0;
      MEM_WB_enable_out <= 1'b0;
      MEM_WB_exc        <= 1'b0;
      MEM_WB_exc_code   <= '0;
    end else if (state == S_IDLE) begin
      if (hazard_flush) begin
        MEM_WB_PC         <= '0;
        MEM_WB_ReadData   <= '0;
        MEM_WB_ALUResult  <= '0;
        MEM_WB_Rd         <= '0;
        MEM_WB_RegWrite   <= 1'b0;
        MEM_WB_MemToReg   <= 1'b0;
        MEM_WB_enable_out <= 1'b0;
        MEM_WB_exc        <= 1'b0;
        MEM_WB_exc_code   <= '0;
      end else if (accept && (!in_is_mem || in_misaligned)) begin
        MEM_WB_PC         <= EX_MEM_PC;
        MEM_WB_ReadData   <= '0;
        MEM_WB_ALUResult  <= EX_MEM_ALUResult;
        MEM_WB_Rd         <= EX_MEM_Rd;
        MEM_WB_MemToReg   <= EX_MEM_MemToReg;
        MEM_WB_enable_out <= 1'b1;
        MEM_WB_RegWrite   <= in_is_mem ? 1'b0 : EX_MEM_RegWrite;
        MEM_WB_exc        <= in_is_mem;
        MEM_WB_exc_code   <= in_is_mem ? 2'b01 : 2'b00;
      end else begin
        MEM_WB_enable_out <= 1'b0;
      end
    end else if (fin_store || fin_load || fin_timeout) begin
      MEM_WB_PC         <= cap_pc;
      MEM_WB_ReadData   <= fin_load ? load_data : '0;
      MEM_WB_ALUResult  <= cap_alu;
      MEM_WB_Rd         <= cap_rd;
      MEM_WB_RegWrite   <= fin_timeout ? 1'b0 : cap_regwrite;
      MEM_WB_MemToReg   <= cap_memtoreg;
      MEM_WB_enable_out <= 1'b1;
      MEM_WB_exc        <= fin_timeout;
      MEM_WB_exc_code   <= fin_timeout ? 2'b10 : 2'b00;
    end else begin
      MEM_WB_enable_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a 32-bit and a 64-bit instance share
// all stimulus except the EX/MEM valid strobe, so each test targets one.
module tb_mem_stage_lsu;

  logic        clk;
  logic        reset_n;
  logic        hazard_stall;
  logic        hazard_flush;
  logic        en32;
  logic        en64;
  logic [31:0] pc;
  logic [63:0] alu;
  logic [63:0] wdata;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_write;
  logic        gnt;
  logic        rvalid;
  logic [63:0] rdata;

  logic        req32, we32, busy32, rw32, m2r32, eno32, exc32;
  logic [31:0] addr32, wd32, wbpc32, rdd32, alu32o;
  logic [3:0]  be32;
  logic [4:0]  rd32o;
  logic [1:0]  code32;

  logic        req64, we64, busy64, rw64, m2r64, eno64, exc64;
  logic [31:0] addr64, wbpc64;
  logic [63:0] wd64, rdd64, alu64o;
  logic [7:0]  be64;
  logic [4:0]  rd64o;
  logic [1:0]  code64;

  int checks = 0;
  int errors = 0;

  mem_stage_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .CNT_WIDTH(8)) dut32 (
    .clk(clk), .reset_n(reset_n), .hazard_stall(hazard_stall), .hazard_flush(hazard_flush),
    .EX_MEM_enable_out(en32), .EX_MEM_PC(pc), .EX_MEM_ALUResult(alu[31:0]),
    .EX_MEM_WriteData(wdata[31:0]), .EX_MEM_Funct3(funct3), .EX_MEM_Rd(rd),
    .EX_MEM_MemRead(mem_read), .EX_MEM_MemWrite(mem_write), .EX_MEM_MemToReg(mem_to_reg),
    .EX_MEM_RegWrite(reg_write), .dmem_req(req32), .dmem_we(we32), .dmem_addr(addr32),
    .dmem_wdata(wd32), .dmem_be(be32), .dmem_gnt(gnt), .dmem_rvalid(rvalid),
    .dmem_rdata(rdata[31:0]), .mem_busy(busy32), .MEM_WB_PC(wbpc32), .MEM_WB_ReadData(rdd32),
    .MEM_WB_ALUResult(alu32o), .MEM_WB_Rd(rd32o), .MEM_WB_RegWrite(rw32),
    .MEM_WB_MemToReg(m2r32), .MEM_WB_enable_out(eno32), .MEM_WB_exc(exc32),
    .MEM_WB_exc_code(code32)
  );

  mem_stage_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(8), .CNT_WIDTH(8)) dut64 (
    .clk(clk), .reset_n(reset_n), .hazard_stall(hazard_stall), .hazard_flush(hazard_flush),
    .EX_MEM_enable_out(en64), .EX_MEM_PC(pc), .EX_MEM_ALUResult(alu),
    .EX_MEM_WriteData(wdata), .EX_MEM_Funct3(funct3), .EX_MEM_Rd(rd),
    .EX_MEM_MemRead(mem_read), .EX_MEM_MemWrite(mem_write), .EX_MEM_MemToReg(mem_to_reg),
    .EX_MEM_RegWrite(reg_write), .dmem_req(req64), .dmem_we(we64), .dmem_addr(addr64),
    .dmem_wdata(wd64), .dmem_be(be64), .dmem_gnt(gnt), .dmem_rvalid(rvalid),
    .dmem_rdata(rdata), .mem_busy(busy64), .MEM_WB_PC(wbpc64), .MEM_WB_ReadData(rdd64),
    .MEM_WB_ALUResult(alu64o), .MEM_WB_Rd(rd64o), .MEM_WB_RegWrite(rw64),
    .MEM_WB_MemToReg(m2r64), .MEM_WB_enable_out(eno64), .MEM_WB_exc(exc64),
    .MEM_WB_exc_code(code64)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic e32, input logic e64, input logic [31:0] p,
                               input logic [63:0] a, input logic [63:0] w, input logic [2:0] f3,
                               input logic [4:0] r, input logic mr, input logic mw,
                               input logic m2r, input logic rw);
    en32       = e32;
    en64       = e64;
    pc         = p;
    alu        = a;
    wdata      = w;
    funct3     = f3;
    rd         = r;
    mem_read   = mr;
    mem_write  = mw;
    mem_to_reg = m2r;
    reg_write  = rw;
    #1;
  endtask

  task automatic clearOp();
    applyStimulus(1'b0, 1'b0, 32'h0, 64'h0, 64'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Safety net so the run always ends even if the sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    reset_n = 1'b0;
    hazard_stall = 1'b0;
    hazard_flush = 1'b0;
    gnt = 1'b0;
    rvalid = 1'b0;
    rdata = 64'h0;
    clearOp();
    #1;
    checkOutput("reset_req", req32, 0);
    checkOutput("reset_busy", busy32, 0);
    checkOutput("reset_en", eno32, 0);
    checkOutput("reset_pc", wbpc32, 0);
    checkOutput("reset_rd64", rdd64, 0);
    #8 reset_n = 1'b1;

    // LBU at 0x103: gnt next cycle, rvalid two cycles after gnt.
    tick();
    applyStimulus(1, 0, 32'h100, 64'h103, 64'h0, 3'b100, 5'd5, 1, 0, 1, 1);
    checkOutput("lbu_busy_c0", busy32, 1);
    tick();
    clearOp();
    checkOutput("lbu_req", req32, 1);
    checkOutput("lbu_addr", addr32, 32'h100);
    checkOutput("lbu_we", we32, 0);
    checkOutput("lbu_be", be32, 4'b1000);
    checkOutput("lbu_busy_c1", busy32, 1);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    checkOutput("lbu_req_resp", req32, 0);
    checkOutput("lbu_busy_c2", busy32, 1);
    checkOutput("lbu_en_c2", eno32, 0);
    tick();
    rvalid = 1'b1;
    rdata = 64'h80FF_0000;
    checkOutput("lbu_busy_c3", busy32, 1);
    checkOutput("lbu_en_c3", eno32, 0);
    tick();
    rvalid = 1'b0;
    checkOutput("lbu_en", eno32, 1);
    checkOutput("lbu_data", rdd32, 32'h0000_0080);
    checkOutput("lbu_rd", rd32o, 5);
    checkOutput("lbu_pc", wbpc32, 32'h100);
    checkOutput("lbu_exc", exc32, 0);
    checkOutput("lbu_busy_c4", busy32, 0);
    tick();
    checkOutput("lbu_en_pulse", eno32, 0);
    checkOutput("lbu_data_hold", rdd32, 32'h0000_0080);

    // LH at 0x102, sign-extended.
    applyStimulus(1, 0, 32'h104, 64'h102, 64'h0, 3'b001, 5'd6, 1, 0, 1, 1);
    tick();
    clearOp();
    checkOutput("lh_be", be32, 4'b1100);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    rvalid = 1'b1;
    rdata = 64'h8001_1234;
    tick();
    rvalid = 1'b0;
    checkOutput("lh_en", eno32, 1);
    checkOutput("lh_data", rdd32, 32'hFFFF_8001);

    // LW at 0x102: misaligned, no bus access.
    applyStimulus(1, 0, 32'h108, 64'h102, 64'h0, 3'b010, 5'd7, 1, 0, 1, 1);
    checkOutput("lw_mis_busy", busy32, 0);
    tick();
    clearOp();
    checkOutput("lw_mis_en", eno32, 1);
    checkOutput("lw_mis_exc", exc32, 1);
    checkOutput("lw_mis_code", code32, 2'b01);
    checkOutput("lw_mis_rw", rw32, 0);
    checkOutput("lw_mis_req", req32, 0);
    tick();
    checkOutput("lw_mis_req2", req32, 0);

    // SB 0xAB at 0x201 with gnt delayed three cycles.
    applyStimulus(1, 0, 32'h10C, 64'h201, 64'h12AB, 3'b000, 5'd0, 0, 1, 0, 0);
    tick();
    clearOp();
    for (int i = 0; i < 3; i++) begin
      checkOutput("sb_req", req32, 1);
      checkOutput("sb_we", we32, 1);
      checkOutput("sb_addr", addr32, 32'h200);
      checkOutput("sb_be", be32, 4'b0010);
      checkOutput("sb_wdata", wd32, 32'hABAB_ABAB);
      if (i == 2) gnt = 1'b1;
      tick();
    end
    gnt = 1'b0;
    checkOutput("sb_en", eno32, 1);
    checkOutput("sb_data", rdd32, 0);
    checkOutput("sb_exc", exc32, 0);
    checkOutput("sb_req_done", req32, 0);

    // LW with no gnt: timeout after 8 cycles in REQ.
    applyStimulus(1, 0, 32'h110, 64'h300, 64'h0, 3'b010, 5'd7, 1, 0, 1, 1);
    tick();
    clearOp();
    for (int i = 0; i < 8; i++) begin
      checkOutput("to_req", req32, 1);
      checkOutput("to_en_wait", eno32, 0);
      tick();
    end
    checkOutput("to_en", eno32, 1);
    checkOutput("to_exc", exc32, 1);
    checkOutput("to_code", code32, 2'b10);
    checkOutput("to_rw", rw32, 0);
    checkOutput("to_req_done", req32, 0);
    checkOutput("to_busy", busy32, 0);

    // Flush during RESP, rvalid two cycles later, then an ADD.
    applyStimulus(1, 0, 32'h114, 64'h400, 64'h0, 3'b010, 5'd8, 1, 0, 1, 1);
    tick();
    clearOp();
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    hazard_flush = 1'b1;
    tick();
    hazard_flush = 1'b0;
    checkOutput("fl_en_c1", eno32, 0);
    checkOutput("fl_busy_c1", busy32, 1);
    tick();
    rvalid = 1'b1;
    rdata = 64'hDEAD_BEEF;
    checkOutput("fl_busy_c2", busy32, 1);
    tick();
    rvalid = 1'b0;
    checkOutput("fl_en_none", eno32, 0);
    checkOutput("fl_busy_done", busy32, 0);
    applyStimulus(1, 0, 32'h118, 64'h1234, 64'h0, 3'b000, 5'd9, 0, 0, 0, 1);
    checkOutput("add_busy", busy32, 0);
    tick();
    clearOp();
    checkOutput("add_en", eno32, 1);
    checkOutput("add_alu", alu32o, 32'h1234);
    checkOutput("add_rd", rd32o, 9);
    checkOutput("add_rw", rw32, 1);
    checkOutput("add_exc", exc32, 0);
    tick();
    checkOutput("add_en_pulse", eno32, 0);

    // 64-bit LD at 0x8 returns rdata unchanged.
    applyStimulus(0, 1, 32'h200, 64'h8, 64'h0, 3'b011, 5'd10, 1, 0, 1, 1);
    tick();
    clearOp();
    checkOutput("ld_req", req64, 1);
    checkOutput("ld_addr", addr64, 32'h8);
    checkOutput("ld_be", be64, 8'hFF);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    rvalid = 1'b1;
    rdata = 64'h8123_4567_89AB_CDEF;
    tick();
    rvalid = 1'b0;
    checkOutput("ld_en", eno64, 1);
    checkOutput("ld_data", rdd64, 64'h8123_4567_89AB_CDEF);

    // 64-bit LWU at 0xC: upper half zero-extended.
    applyStimulus(0, 1, 32'h204, 64'hC, 64'h0, 3'b110, 5'd11, 1, 0, 1, 1);
    tick();
    clearOp();
    checkOutput("lwu_addr", addr64, 32'h8);
    checkOutput("lwu_be", be64, 8'hF0);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    rvalid = 1'b1;
    rdata = 64'hF234_5678_0000_0000;
    tick();
    rvalid = 1'b0;
    checkOutput("lwu_en", eno64, 1);
    checkOutput("lwu_data", rdd64, 64'h0000_0000_F234_5678);

    // Back-to-back ALU ops with hazard_stall toggling.
    for (int i = 0; i < 6; i++) begin
      logic stalled;
      stalled = (i % 2) == 1;
      hazard_stall = stalled;
      applyStimulus(0, 1, 32'h300 + 32'(i * 4), 64'(i + 16), 64'h0, 3'b000, 5'(i + 1), 0, 0, 0, 1);
      tick();
      checkOutput("stall_en", eno64, stalled ? 1'b0 : 1'b1);
      if (!stalled) checkOutput("stall_alu", alu64o, 64'(i + 16));
    end
    hazard_stall = 1'b0;
    clearOp();

    // Asynchronous reset in the middle of a request.
    applyStimulus(1, 0, 32'h400, 64'h700, 64'h0, 3'b010, 5'd12, 1, 0, 1, 1);
    tick();
    clearOp();
    checkOutput("rst_req_before", req32, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_req", req32, 0);
    checkOutput("rst_busy", busy32, 0);
    checkOutput("rst_en", eno32, 0);
    #1 reset_n = 1'b1;
    tick();
    checkOutput("rst_req_after", req32, 0);
    checkOutput("rst_en_after", eno32, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised next-generation pipeline memory stage. Sits between EX/MEM and MEM/WB registers.
- Adds sized and signed loads/stores, byte enables and a req/gnt/rvalid data-bus handshake with variable latency.
- Adds a misalignment/bus-error exception path, a response timeout, and a busy output that the hazard unit uses to stall upstream stages.

Parameters:
- ADDR_WIDTH, 32, data-bus address width.
- DATA_WIDTH, 32, data/register width; legal values are 32 and 64.
- TIMEOUT_CYCLES, 64, cycles spent in REQ+RESP before a bus error is declared; must be ≥2.
- CNT_WIDTH, 8, timeout counter width; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- hazard_stall  in  1  hold: accept nothing new
- hazard_flush  in  1  kill the current and incoming op
- EX_MEM_enable_out  in  1  EX/MEM entry valid
- EX_MEM_PC  in  32  PC
- EX_MEM_ALUResult  in  DATA_WIDTH  address or result; address = low ADDR_WIDTH bits
- EX_MEM_WriteData  in  DATA_WIDTH  store data, right-aligned
- EX_MEM_Funct3  in  3  [1:0] size (00 B, 01 H, 10 W, 11 D); [2] unsigned load
- EX_MEM_Rd  in  5  destination register
- EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg, EX_MEM_RegWrite  in  1 each  controls
- dmem_req  out  1  bus request
- dmem_we  out  1  write
- dmem_addr  out  ADDR_WIDTH  address, aligned down to DATA_WIDTH/8
- dmem_wdata  out  DATA_WIDTH  lane-replicated store data
- dmem_be  out  DATA_WIDTH/8  byte enables
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  DATA_WIDTH  read data
- mem_busy  out  1  stage cannot accept
- MEM_WB_PC  out  32
- MEM_WB_ReadData  out  DATA_WIDTH  formatted load data
- MEM_WB_ALUResult  out  DATA_WIDTH
- MEM_WB_Rd  out  5
- MEM_WB_RegWrite  out  1
- MEM_WB_MemToReg  out  1
- MEM_WB_enable_out  out  1  one-cycle retire pulse
- MEM_WB_exc  out  1  exception on retired op
- MEM_WB_exc_code  out  2  01 misaligned/illegal size, 10 bus timeout

Behaviour:
- Reset: all outputs 0, FSM in IDLE, timeout counter 0.
- FSM states: IDLE, REQ, RESP, DRAIN.
- Accept: in IDLE with EX_MEM_enable_out && !hazard_stall && !hazard_flush.
- Non-memory op (MemRead=MemWrite=0): MEM_WB_* registered next edge; 1-cycle latency; stays in IDLE.
- Misaligned check: address offset not a multiple of size, or size 11 with DATA_WIDTH=32.
  - Retire next edge with exc=1, code=01, RegWrite=0; no bus access.
  - MemRead and MemWrite both set is treated as a load.
- Legal memory op: capture operands into internal registers and go to REQ.
  - dmem_req=1 in REQ only; addr/we/be/wdata held stable until dmem_gnt.
  - be = ((1<<bytes)-1) << offset.
  - wdata = low bytes of WriteData replicated across all lanes.
- Store: on gnt, retire at the next edge (RegWrite as captured, ReadData=0), go to IDLE.
  - Minimum store latency: accept edge + 1 REQ cycle.
- Load: on gnt go to RESP; on dmem_rvalid, retire at that edge and go to IDLE.
  - ReadData = (rdata >> 8*offset) truncated to size, zero-extended if Funct3[2]=1, else sign-extended to DATA_WIDTH.
  - rvalid arriving in the same cycle as gnt is not permitted; the bus guarantees rvalid ≥1 cycle after gnt.
- mem_busy = (state≠IDLE) | (IDLE && accepting a legal memory op). It is combinational so the upstream register holds.
- hazard_stall: in IDLE it blocks acceptance and sets MEM_WB_enable_out=0. It is ignored in REQ/RESP/DRAIN.
- hazard_flush:
  - IDLE: clear all MEM_WB_* to 0 and accept nothing.
  - REQ without gnt the same cycle: drop req, go to IDLE, no retire.
  - REQ with gnt the same cycle, on a load: go to DRAIN.
  - REQ with gnt the same cycle, on a store: the store has been issued, but it does not retire.
  - RESP: go to DRAIN.
  - DRAIN: wait for rvalid, discard it, go to IDLE; mem_busy stays 1.
- Timeout: counter is cleared on entering REQ and increments each cycle in REQ/RESP. At TIMEOUT_CYCLES:
  - Retire with exc=1, code=10, RegWrite=0; go to IDLE.
  - A late rvalid arriving in IDLE is ignored.
- MEM_WB_enable_out is high for exactly one cycle per retired op. Other MEM_WB_* outputs hold their values between retires.
- Asynchronous reset mid-transaction: immediate return to IDLE with dmem_req=0; no retire.

Test Plan:
- DATA_WIDTH=32; LBU at addr 0x103, gnt next cycle, rvalid 2 cycles later, rdata=0x80FF_0000 -> ReadData=0x00000080, enable_out single pulse, mem_busy high for 4 cycles.
- LH at 0x102, rdata=0x8001_xxxx -> ReadData=0xFFFF8001; LW at 0x102 -> exc=1, code=01, dmem_req never asserted.
- SB 0xAB at 0x201 with gnt delayed 3 cycles -> dmem_be=0010, dmem_wdata=0xABABABAB held stable for 3 cycles, retire on the cycle after gnt.
- Load with no gnt, TIMEOUT_CYCLES=8 -> retire at cycle 8 in REQ with exc=1, code=10, RegWrite=0.
- hazard_flush during RESP, rvalid arrives 2 cycles later -> no retire, mem_busy stays 1 until rvalid, a following ADD retires normally.
- DATA_WIDTH=64: LD at 0x8 returns 64-bit rdata unchanged; LW unsigned at 0xC -> upper half zero-extended; back-to-back ALU ops with hazard_stall toggling -> enable_out=0 exactly on the stalled cycles.
